// File: rtl/regfile_param.sv
// regfile_param: parametrised CPU register file with two combinational read
// ports, one clocked write port, optional hardwired zero register, optional
// write-to-read bypass and a sequential clear engine.
//
// The clear engine walks the array one entry per cycle after reset or on a
// clear_req, writing a fill value (zero, or the entry index) into each entry.
// While it runs, busy is high, reads return zero and writes are dropped.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (restarts the clear walk)
//   clear_req      one-cycle request to re-run the clear engine (READY only)
//   read_address_0 / read_address_1   read addresses
//   read_data_0    / read_data_1      combinational read data
//   write_en, write_address, write_data   clocked write port
//   busy           clear engine active
//   write_dropped  one-cycle pulse: a write was attempted while busy
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter bit INIT_MODE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic [ADDR_WIDTH-1:0] read_address_0,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  output logic [DATA_WIDTH-1:0] read_data_0,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  write_dropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   fill_value;
  logic                    zero_write;
  logic                    user_write;
  logic                    last_entry;

  assign fill_value = INIT_MODE ? DATA_WIDTH'(clr_ptr) : '0;
  assign last_entry = (clr_ptr == ADDR_WIDTH'(DEPTH - 1));

  // A write to the hardwired zero entry is discarded silently.
  assign zero_write = ZERO_REG && (write_address == '0);
  assign user_write = (state == READY) && write_en && !zero_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      busy          <= 1'b1;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= (state == CLEAR) && write_en;
      case (state)
        CLEAR: begin
          if (last_entry) begin
            state   <= READY;
            busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          busy    <= 1'b1;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  // Array has no reset; held off while rst is high so an in-flight write is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= fill_value;
      end else if (user_write) begin
        mem[write_address] <= write_data;
      end
    end
  end

  always_comb begin
    read_data_0 = mem[read_address_0];
    if (busy) begin
      read_data_0 = '0;
    end else if (ZERO_REG && (read_address_0 == '0)) begin
      read_data_0 = '0;
    end else if (BYPASS && user_write && (write_address == read_address_0)) begin
      read_data_0 = write_data;
    end
  end

  always_comb begin
    read_data_1 = mem[read_address_1];
    if (busy) begin
      read_data_1 = '0;
    end else if (ZERO_REG && (read_address_1 == '0)) begin
      read_data_1 = '0;
    end else if (BYPASS && user_write && (write_address == read_address_1)) begin
      read_data_1 = write_data;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param. Two instances share the
// stimulus: dut (ZERO_REG=1, BYPASS=1, INIT_MODE=1) and dut_nb (ZERO_REG=0,
// BYPASS=0, INIT_MODE=0). Inputs change and outputs are sampled 1 time unit
// after the rising edge.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic [4:0]  read_address_0, read_address_1, write_address;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] rd0, rd1, nb_rd0, nb_rd1;
  logic        busy, nb_busy, wdrop, nb_wdrop;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1),
                  .BYPASS(1'b1), .INIT_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .read_address_0(read_address_0), .read_address_1(read_address_1),
    .read_data_0(rd0), .read_data_1(rd1),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .busy(busy), .write_dropped(wdrop)
  );

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0),
                  .BYPASS(1'b0), .INIT_MODE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .read_address_0(read_address_0), .read_address_1(read_address_1),
    .read_data_0(nb_rd0), .read_data_1(nb_rd1),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .busy(nb_busy), .write_dropped(nb_wdrop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b0; write_en = 1'b0;
    write_address = '0; write_data = '0;
    read_address_0 = 5'd7; read_address_1 = 5'd0;
    step(); step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_nb_busy", 32'(nb_busy), 32'd1);
    check("rst_wdrop", 32'(wdrop), 32'd0);
    check("rst_rd0", rd0, 32'd0);

    // Release reset; count clear cycles, drop a write and ignore a clear_req.
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      write_en = (n == 3);
      write_address = 5'd3;
      write_data = 32'h55;
      clear_req = (n == 10);
      step();
      n++;
      if (n == 4) check("drop_pulse", 32'(wdrop), 32'd1);
      if (n == 5) check("drop_end", 32'(wdrop), 32'd0);
      if (n == 8) check("busy_rd0_zero", rd0, 32'd0);
    end
    write_en = 1'b0; clear_req = 1'b0;
    check("init_clear_len", 32'(n), 32'd32);
    check("nb_ready", 32'(nb_busy), 32'd0);
    #1;
    check("init_rd_a7", rd0, 32'd7);
    check("init_rd_a0", rd1, 32'd0);
    check("nb_init_a7", nb_rd0, 32'd0);
    read_address_0 = 5'd3; #1;
    check("dropped_a3", rd0, 32'd3);
    check("nb_dropped_a3", nb_rd0, 32'd0);

    // Bypass vs no bypass.
    read_address_0 = 5'd5; write_en = 1'b1; write_address = 5'd5;
    write_data = 32'hDEADBEEF; #1;
    check("bypass_same_cycle", rd0, 32'hDEADBEEF);
    check("nb_old_value", nb_rd0, 32'd0);
    step();
    write_en = 1'b0; #1;
    check("bypass_after", rd0, 32'hDEADBEEF);
    check("nb_new_value", nb_rd0, 32'hDEADBEEF);
    check("ready_no_drop", 32'(wdrop), 32'd0);

    // Zero register.
    read_address_0 = 5'd0; read_address_1 = 5'd0;
    write_en = 1'b1; write_address = 5'd0; write_data = 32'h1234; #1;
    check("zero_rd0_bypass", rd0, 32'd0);
    check("zero_rd1_bypass", rd1, 32'd0);
    step();
    write_en = 1'b0; #1;
    check("zero_rd0", rd0, 32'd0);
    check("zero_rd1", rd1, 32'd0);
    check("zero_no_drop", 32'(wdrop), 32'd0);
    check("nb_a0_rd0", nb_rd0, 32'h1234);
    check("nb_a0_rd1", nb_rd1, 32'h1234);

    read_address_0 = 5'd5; read_address_1 = 5'd5; #1;
    check("same_addr_p0", rd0, 32'hDEADBEEF);
    check("same_addr_p1", rd1, 32'hDEADBEEF);

    // clear_req with a same-edge write to address 9.
    read_address_0 = 5'd9;
    write_en = 1'b1; write_address = 5'd9; write_data = 32'hAA; clear_req = 1'b1;
    step();
    write_en = 1'b0; clear_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_busy_rd", rd0, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      clear_req = (n == 5);
      step();
      n++;
    end
    clear_req = 1'b0;
    check("clr_len", 32'(n), 32'd32);
    #1;
    check("clr_a9", rd0, 32'd9);
    check("nb_clr_a9", nb_rd0, 32'd0);
    read_address_0 = 5'd5; #1;
    check("clr_a5", rd0, 32'd5);

    // Mark entry 20, then reset when the walk reaches entry 17.
    write_en = 1'b1; write_address = 5'd20; write_data = 32'h777;
    step();
    write_en = 1'b0; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 17; i++) step();
    rst = 1'b1; #1;
    check("midrst_busy", 32'(busy), 32'd1);
    step();
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("midrst_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      read_address_0 = 5'(i); read_address_1 = 5'(31 - i); #1;
      check("fill_p0", rd0, 32'(i));
      check("fill_p1", rd1, 32'(31 - i));
      check("nb_fill_p0", nb_rd0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Next-generation CPU register file.
- Features: parametrised width and depth, two combinational read ports, one clocked write port, optional hardwired zero register, optional write-to-read bypass.
- Replaces whole-array initialisation with a sequential clear engine: it walks the array one entry per cycle after reset or on request.
- Sits between decode (read addresses) and writeback (write port) in the multicycle datapath.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to read data.
- INIT_MODE, 0, clear-engine fill value: 0 = all zeros, 1 = entry index zero-extended/truncated to DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_req  in  1  one-cycle request to re-run the clear engine.
- read_address_0  in  ADDR_WIDTH  read port 0 address.
- read_address_1  in  ADDR_WIDTH  read port 1 address.
- read_data_0  out  DATA_WIDTH  read port 0 data, combinational.
- read_data_1  out  DATA_WIDTH  read port 1 data, combinational.
- write_en  in  1  write strobe, sampled at clk rise.
- write_address  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- busy  out  1  clear engine active; writes are dropped.
- write_dropped  out  1  registered one-cycle pulse: a write was attempted while busy.

Behaviour:
- Reset is asynchronous and active-high.
  - rst high: FSM = CLEAR, clr_ptr = 0, busy = 1, write_dropped = 0.
  - Array contents are not reset directly.
  - read_data_* = 0 while busy.
- FSM states: CLEAR, READY.
  - CLEAR: each clk writes fill(clr_ptr) into entry clr_ptr, then clr_ptr += 1.
  - When clr_ptr == DEPTH-1 is written, go to READY on the same edge; clr_ptr returns to 0.
  - CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - READY: clear_req = 1 at a clk edge → CLEAR with clr_ptr = 0; busy = 1 from the next cycle.
  - clear_req during CLEAR is ignored; the walk does not restart.
- busy = 1 iff state == CLEAR (registered output).
- Write, READY only: write_en at clk rise stores write_data into entry write_address.
  - Latency: the value is visible on an ordinary read the cycle after the edge.
  - ZERO_REG = 1 and write_address == 0: the write is discarded silently; no write_dropped pulse.
- Write while busy (write_en = 1, state CLEAR): the write is discarded; write_dropped = 1 for the following cycle.
- Simultaneous clear_req and write_en in READY: the write completes on that edge, then the clear starts and overwrites it.
- Read, READY:
  - read_data_n = entry[read_address_n].
  - ZERO_REG = 1 and read_address_n == 0 → 0.
  - BYPASS = 1, write_en = 1, write_address == read_address_n, and the address is not a discarded zero-register write → read_data_n = write_data in the same cycle.
  - BYPASS = 0 → old contents until the edge.
- Both read ports may address the same entry; both return identical data.
- rst asserted mid-CLEAR or mid-write: immediate return to CLEAR at clr_ptr = 0; an in-flight write is lost.
- clr_ptr is ADDR_WIDTH+1 bits or compared against DEPTH-1; it must not wrap silently into a second pass.

Test Plan:
- Reset release, INIT_MODE = 1, ADDR_WIDTH = 5 → busy = 1 for 32 cycles then 0; reading address 7 returns 7; address 0 returns 0.
- READY, write 0xDEADBEEF to address 5 with read_address_0 = 5, BYPASS = 1 → read_data_0 = 0xDEADBEEF in the same cycle; BYPASS = 0 → old value, new value next cycle.
- ZERO_REG = 1, write 0x1234 to address 0 → both ports read address 0 as 0; write_dropped stays 0.
- write_en = 1 to address 3 during CLEAR → write_dropped pulses 1 cycle; after READY, address 3 holds its fill value.
- clear_req with a same-edge write of 0xAA to address 9 → busy for 32 cycles; afterwards address 9 = fill value (0 or 9); clear_req repeated mid-clear does not lengthen busy.
- rst pulsed at clr_ptr = 17 → busy stays 1 for a full 32 cycles after release; all entries hold fill values.
